alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  request an operation; sampled only in IDLE.
REQ-004 op  input  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 NOT B.
REQ-005 rn  input  3  register index for operand A.
REQ-006 rm  input  3  register index for operand B.
REQ-007 rd  input  3  destination register index.
REQ-008 shift  input  2  B pre-shift: 00 none, 01 LSL1, 10 LSR1, 11 ASR1.
REQ-009 wr_en / wr_addr / wr_data  input  1/3/16  external register load port.
REQ-010 obs_addr  input  3; obs_data  output  16  combinational register read-back port.
REQ-011 val_A, val_B  output  16; ALU_op  output  2  drive the ALU.
REQ-012 ALU_out  input  16; Z  input  1  ALU result and zero flag.
REQ-013 busy  output  1  high from LOAD_A through WRITE.
REQ-014 done  output  1  one-cycle pulse in WRITE.
REQ-015 result  output  16  last captured ALU result (register C).
REQ-016 status_Z  output  1  last captured zero flag.

Function
REQ-017 Register file SHALL hold 8 x 16-bit registers R0..R7; R0 is an ordinary register.
REQ-018 FSM SHALL use states IDLE -> LOAD_A -> LOAD_B -> EXEC -> WRITE -> IDLE, with one cycle per state.
REQ-019 IDLE SHALL move to LOAD_A on start=1; start outside IDLE SHALL be ignored, not queued.
REQ-020 rn, rm, rd, op and shift SHALL be latched on the accepting edge; later input changes have no effect.
REQ-021 LOAD_A SHALL register A <= R[rn].
REQ-022 LOAD_B SHALL register B <= shift(R[rm]).
  - LSL1/LSR1 fill with 0.
  - ASR1 replicates bit 15.
  - All results are 16-bit, with no widening.
REQ-023 val_A/val_B SHALL drive registers A/B continuously; ALU_op SHALL drive the latched op continuously.
REQ-024 EXEC SHALL capture C <= ALU_out and status_Z <= Z on its closing edge.
REQ-025 WRITE SHALL commit R[rd] <= C and assert done; done rises exactly 4 cycles after the start-accepting edge.
REQ-026 External write SHALL be accepted only in IDLE; wr_en while busy SHALL be dropped.
REQ-027 start and wr_en asserted in the same IDLE cycle: the write commits, and LOAD_A/LOAD_B read the post-write value.
REQ-028 rn=rm=rd is legal; the read-before-write order of the FSM guarantees correct results.
REQ-029 obs_data = R[obs_addr] SHALL reflect the register file state after the latest edge.

Reset
REQ-030 rst_n=0 SHALL immediately set:
  - FSM to IDLE;
  - R0..R7, A, B and C to 16'h0000;
  - latched op/indices/shift to 0;
  - status_Z, busy and done to 0.
REQ-031 Reset mid-operation SHALL abort with no register-file write; the first start after release restarts from LOAD_A.

Structure
REQ-032 Shared package cpu_pkg SHALL define:
  - FSM state enum;
  - ALU op encodings;
  - shift encodings;
  - register width (16) and register count (8).
REQ-033 The register file SHALL be a sub-module named regfile: 1 synchronous write port, 3 combinational read ports (A, B, obs), async active-low reset.

Verification
REQ-034 Reset: assert rst_n=0 mid-cycle -> busy=0, done=0, result=0, status_Z=0, all obs_data=0 without waiting for a clock edge.
REQ-035 ADD: load R1=1, R2=1; start op=00 rn=1 rm=2 rd=3 shift=00 -> val_A=1 and val_B=1 in EXEC; done 4 cycles after accept; R3=2; status_Z=0.
REQ-036 SUB with shift: R1=2, R2=1; op=01 rn=1 rm=2 rd=4 shift=01 -> B=2, R4=0, status_Z=1.
REQ-037 ASR/NOT: R5=16'h8000; op=11 rm=5 rd=6 shift=11 -> B=16'hC000, R6=16'h3FFF, status_Z=0.
REQ-038 Busy drops:
  - start and wr_en (R7=16'h1234) pulsed during EXEC -> no second operation, R7 unchanged.
  - Same-cycle start+wr_en in IDLE to R1=5, op=00 rn=1 rm=1 -> result=10.
REQ-039 Abort: rst_n=0 during EXEC of a write to R3 -> R3=0, done never pulses, busy=0 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types, encodings and sizes for the ALU issue block
package cpu_pkg;

    localparam int REG_W = 16;
    localparam int REG_N = 8;
    localparam int IDX_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WRITE  = 3'd4
    } state_t;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_NOTB = 2'b11;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL1 = 2'b01;
    localparam logic [1:0] SH_LSR1 = 2'b10;
    localparam logic [1:0] SH_ASR1 = 2'b11;

    // Single-bit pre-shift of operand B; width never grows.
    function automatic logic [REG_W-1:0] shift_b(input logic [REG_W-1:0] v, input logic [1:0] sh);
        case (sh)
            SH_LSL1: shift_b = {v[REG_W-2:0], 1'b0};
            SH_LSR1: shift_b = {1'b0, v[REG_W-1:1]};
            SH_ASR1: shift_b = {v[REG_W-1], v[REG_W-1:1]};
            default: shift_b = v;
        endcase
    endfunction

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - 8x16 register file, one sync write port, three combinational read ports
module regfile
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [REG_W-1:0] wdata,
    input  logic [IDX_W-1:0] raddr_a,
    output logic [REG_W-1:0] rdata_a,
    input  logic [IDX_W-1:0] raddr_b,
    output logic [REG_W-1:0] rdata_b,
    input  logic [IDX_W-1:0] raddr_o,
    output logic [REG_W-1:0] rdata_o
);

    logic [REG_W-1:0] regs [REG_N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_N; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];
    assign rdata_o = regs[raddr_o];

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - register-file sequencer that feeds an external ALU and writes back its result
module alu_issue
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [2:0]  rn,
    input  logic [2:0]  rm,
    input  logic [2:0]  rd,
    input  logic [1:0]  shift,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic [2:0]  obs_addr,
    output logic [15:0] obs_data,
    output logic [15:0] val_A,
    output logic [15:0] val_B,
    output logic [1:0]  ALU_op,
    input  logic [15:0] ALU_out,
    input  logic        Z,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        status_Z
);

    state_t           state;
    logic [1:0]       op_q;
    logic [1:0]       shift_q;
    logic [IDX_W-1:0] rn_q;
    logic [IDX_W-1:0] rm_q;
    logic [IDX_W-1:0] rd_q;
    logic [REG_W-1:0] a_q;
    logic [REG_W-1:0] b_q;
    logic [REG_W-1:0] c_q;
    logic             z_q;

    logic             rf_we;
    logic [IDX_W-1:0] rf_waddr;
    logic [REG_W-1:0] rf_wdata;
    logic [REG_W-1:0] rf_rdata_a;
    logic [REG_W-1:0] rf_rdata_b;

    // The write port is shared: external loads own it in IDLE, write-back owns it in WRITE.
    assign rf_we    = ((state == ST_IDLE) && wr_en) || (state == ST_WRITE);
    assign rf_waddr = (state == ST_WRITE) ? rd_q : wr_addr;
    assign rf_wdata = (state == ST_WRITE) ? c_q  : wr_data;

    regfile u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (rn_q),
        .rdata_a (rf_rdata_a),
        .raddr_b (rm_q),
        .rdata_b (rf_rdata_b),
        .raddr_o (obs_addr),
        .rdata_o (obs_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            op_q    <= '0;
            shift_q <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            rd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            z_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_LOAD_A;
                        op_q    <= op;
                        shift_q <= shift;
                        rn_q    <= rn;
                        rm_q    <= rm;
                        rd_q    <= rd;
                    end
                end
                ST_LOAD_A: begin
                    a_q   <= rf_rdata_a;
                    state <= ST_LOAD_B;
                end
                ST_LOAD_B: begin
                    b_q   <= shift_b(rf_rdata_b, shift_q);
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    c_q   <= ALU_out;
                    z_q   <= Z;
                    state <= ST_WRITE;
                end
                ST_WRITE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign val_A    = a_q;
    assign val_B    = b_q;
    assign ALU_op   = op_q;
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_WRITE);
    assign result   = c_q;
    assign status_Z = z_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - randomized self-checking bench for alu_issue against an operation-level model
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [2:0]  rn;
    logic [2:0]  rm;
    logic [2:0]  rd;
    logic [1:0]  shift;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  obs_addr;
    logic [15:0] obs_data;
    logic [15:0] val_A;
    logic [15:0] val_B;
    logic [1:0]  ALU_op;
    logic [15:0] ALU_out;
    logic        Z;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        status_Z;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .rn       (rn),
        .rm       (rm),
        .rd       (rd),
        .shift    (shift),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .obs_addr (obs_addr),
        .obs_data (obs_data),
        .val_A    (val_A),
        .val_B    (val_B),
        .ALU_op   (ALU_op),
        .ALU_out  (ALU_out),
        .Z        (Z),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .status_Z (status_Z)
    );

    // External ALU the block drives
    always_comb begin
        ALU_out = '0;
        case (ALU_op)
            2'b00: ALU_out = val_A + val_B;
            2'b01: ALU_out = val_A - val_B;
            2'b10: ALU_out = val_A & val_B;
            2'b11: ALU_out = ~val_B;
            default: ALU_out = '0;
        endcase
    end
    assign Z = (ALU_out == 16'h0000);

    function automatic logic [15:0] ref_shift(input logic [15:0] v, input logic [1:0] s);
        int unsigned x;
        x = v;
        case (s)
            2'b01: x = (x * 2) % 65536;
            2'b10: x = x / 2;
            2'b11: x = (x / 2) + (x >= 32768 ? 32768 : 0);
            default: x = v;
        endcase
        return 16'(x);
    endfunction

    function automatic logic [15:0] ref_alu(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        int unsigned x;
        case (o)
            2'b00: x = (int'(a) + int'(b)) % 65536;
            2'b01: x = (65536 + int'(a) - int'(b)) % 65536;
            2'b10: x = a & b;
            default: x = 65535 - int'(b);
        endcase
        return 16'(x);
    endfunction

    // Operation-level model: m_cnt counts cycles since acceptance (0 = idle, 4 = write-back cycle)
    logic [15:0] mregs [8];
    int          m_cnt;
    logic [15:0] m_a;
    logic [15:0] m_b;
    logic [15:0] m_pend;
    logic [15:0] m_res;
    logic        m_z;
    logic [1:0]  m_op;
    logic [2:0]  m_rd;

    function automatic logic [15:0] post_write(input logic [2:0] i);
        return (wr_en && wr_addr == i) ? wr_data : mregs[i];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) mregs[i] <= 16'h0000;
            m_cnt  <= 0;
            m_a    <= '0;
            m_b    <= '0;
            m_pend <= '0;
            m_res  <= '0;
            m_z    <= 1'b0;
            m_op   <= '0;
            m_rd   <= '0;
        end else if (m_cnt == 0) begin
            if (wr_en) mregs[wr_addr] <= wr_data;
            if (start) begin
                m_a    <= post_write(rn);
                m_b    <= ref_shift(post_write(rm), shift);
                m_pend <= ref_alu(op, post_write(rn), ref_shift(post_write(rm), shift));
                m_op   <= op;
                m_rd   <= rd;
                m_cnt  <= 1;
            end
        end else if (m_cnt == 4) begin
            mregs[m_rd] <= m_pend;
            m_cnt       <= 0;
        end else begin
            if (m_cnt == 3) begin
                m_res <= m_pend;
                m_z   <= (m_pend == 16'h0000);
            end
            m_cnt <= m_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 16'(busy), 16'(m_cnt != 0));
            chk("done", 16'(done), 16'(m_cnt == 4));
            chk("result", result, m_res);
            chk("status_Z", 16'(status_Z), 16'(m_z));
            chk("obs_data", obs_data, mregs[obs_addr]);
            if (m_cnt == 3) begin
                chk("val_A", val_A, m_a);
                chk("val_B", val_B, m_b);
                chk("ALU_op", 16'(ALU_op), 16'(m_op));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic chk_reg(input string name, input logic [2:0] i, input logic [15:0] e);
        obs_addr = i;
        #1;
        chk(name, obs_data, e);
    endtask

    // Issues one operation; later field changes and optional busy-time pokes must have no effect
    task automatic run_op(input logic [1:0] o, input logic [2:0] a, input logic [2:0] b,
                          input logic [2:0] d, input logic [1:0] s, input bit poke,
                          output int done_k, output int done_n,
                          output logic [15:0] ea, output logic [15:0] eb);
        start  = 1'b1;
        op     = o;
        rn     = a;
        rm     = b;
        rd     = d;
        shift  = s;
        done_k = 0;
        done_n = 0;
        ea     = '0;
        eb     = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 3) begin
                ea = val_A;
                eb = val_B;
            end
            if (done) begin
                done_n++;
                if (done_k == 0) done_k = k;
            end
            #1;
            if (k == 1) begin
                start = 1'b0;
                wr_en = 1'b0;
                op    = 2'($urandom);
                rn    = 3'($urandom);
                rm    = 3'($urandom);
                rd    = 3'($urandom);
                shift = 2'($urandom);
            end
            if (poke && k == 3) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_addr = 3'd7;
                wr_data = 16'h1234;
            end
            if (poke && k == 4) begin
                start = 1'b0;
                wr_en = 1'b0;
            end
        end
    endtask

    int          dk;
    int          dn;
    int          seen;
    logic [15:0] ea;
    logic [15:0] eb;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        op       = '0;
        rn       = '0;
        rm       = '0;
        rd       = '0;
        shift    = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        obs_addr = '0;
        step();
        step();
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        step();

        // ADD: 1 + 1 into R3
        load(3'd1, 16'h0001);
        load(3'd2, 16'h0001);
        run_op(2'b00, 3'd1, 3'd2, 3'd3, 2'b00, 1'b0, dk, dn, ea, eb);
        chk("add_done_cycle", 16'(dk), 16'd4);
        chk("add_val_A", ea, 16'h0001);
        chk("add_val_B", eb, 16'h0001);
        chk_reg("add_R3", 3'd3, 16'h0002);
        chk("add_status_Z", 16'(status_Z), 16'h0000);

        // SUB with LSL1: 2 - (1<<1) = 0
        load(3'd1, 16'h0002);
        run_op(2'b01, 3'd1, 3'd2, 3'd4, 2'b01, 1'b0, dk, dn, ea, eb);
        chk("sub_val_B", eb, 16'h0002);
        chk_reg("sub_R4", 3'd4, 16'h0000);
        chk("sub_status_Z", 16'(status_Z), 16'h0001);

        // Mid-cycle reset clears everything without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 16'(busy), 16'h0000);
        chk("rst_done", 16'(done), 16'h0000);
        chk("rst_result", result, 16'h0000);
        chk("rst_status_Z", 16'(status_Z), 16'h0000);
        for (int i = 0; i < 8; i++) chk_reg("rst_obs", 3'(i), 16'h0000);
        step();
        rst_n = 1'b1;
        step();

        // NOT B with ASR1
        load(3'd5, 16'h8000);
        run_op(2'b11, 3'd0, 3'd5, 3'd6, 2'b11, 1'b0, dk, dn, ea, eb);
        chk("notb_val_B", eb, 16'hC000);
        chk_reg("notb_R6", 3'd6, 16'h3FFF);
        chk("notb_status_Z", 16'(status_Z), 16'h0000);

        // start and wr_en during EXEC are dropped
        load(3'd1, 16'h0003);
        load(3'd2, 16'h0004);
        run_op(2'b00, 3'd1, 3'd2, 3'd0, 2'b00, 1'b1, dk, dn, ea, eb);
        chk("busy_drop_done_pulses", 16'(dn), 16'd1);
        chk_reg("busy_drop_R7", 3'd7, 16'h0000);
        chk_reg("busy_drop_R0", 3'd0, 16'h0007);
        chk("busy_drop_idle", 16'(busy), 16'h0000);

        // Same-cycle load and start: operands see the new R1
        wr_en   = 1'b1;
        wr_addr = 3'd1;
        wr_data = 16'h0005;
        run_op(2'b00, 3'd1, 3'd1, 3'd2, 2'b00, 1'b0, dk, dn, ea, eb);
        chk("same_cycle_result", result, 16'h000A);
        chk_reg("same_cycle_R2", 3'd2, 16'h000A);

        // Reset during EXEC aborts the write to R3
        load(3'd3, 16'h00AA);
        start = 1'b1;
        op    = 2'b00;
        rn    = 3'd1;
        rm    = 3'd1;
        rd    = 3'd3;
        shift = 2'b00;
        step();
        start = 1'b0;
        step();
        step();
        chk("abort_in_exec_busy", 16'(busy), 16'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 16'(busy), 16'h0000);
        chk_reg("abort_R3", 3'd3, 16'h0000);
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) seen++;
        end
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) seen++;
        end
        #1;
        chk("abort_no_done", 16'(seen), 16'h0000);
        chk_reg("abort_R3_after", 3'd3, 16'h0000);

        // Randomized traffic, including occasional resets
        for (int c = 0; c < 3000; c++) begin
            start    = ($urandom_range(3) == 0);
            wr_en    = ($urandom_range(2) == 0);
            op       = 2'($urandom);
            rn       = 3'($urandom);
            rm       = 3'($urandom);
            rd       = 3'($urandom);
            shift    = 2'($urandom);
            wr_addr  = 3'($urandom);
            wr_data  = ($urandom_range(7) == 0) ? 16'h8000 : 16'($urandom);
            obs_addr = 3'($urandom);
            rst_n    = ($urandom_range(199) != 0);
            step();
        end
        rst_n = 1'b1;
        start = 1'b0;
        wr_en = 1'b0;
        for (int k = 0; k < 6; k++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
